// File: rtl/nf_hex_arb_pkg.sv
// Shared types and helpers for the hex display arbiter.
package nf_hex_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam int HEX_W = 32;

    // Width of a source index, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nf_rr_pick.sv
// Combinational round-robin picker: first requesting source at or after start, with wrap.
module nf_rr_pick
    import nf_hex_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic          excl_en,
    output logic          found,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);
    logic [N-1:0] masked;
    int           excl;
    int           pos;

    // The excluded source is the one just before start, i.e. the current holder.
    always_comb begin
        found  = 1'b0;
        onehot = '0;
        idx    = '0;
        pos    = 0;
        masked = req;
        excl   = (start == '0) ? (N - 1) : (int'(start) - 1);
        if (excl_en) begin
            masked[excl] = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            pos = (int'(start) + k) % N;
            if (!found && masked[pos]) begin
                found       = 1'b1;
                idx         = IW'(pos);
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nf_hex_arb.sv
// Round-robin arbiter time-sharing the 32-bit hex display, with a minimum dwell per grant.
module nf_hex_arb
    import nf_hex_arb_pkg::*;
#(
    parameter int SRC_NUM = 4,
    parameter int DWELL   = 50_000_000,
    parameter int CNT_W   = 26,
    localparam int ID_W   = id_width(SRC_NUM)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SRC_NUM-1:0]       req,
    input  logic [SRC_NUM*HEX_W-1:0] hex_in,
    input  logic                     freeze,
    output logic [SRC_NUM-1:0]       grant,
    output logic [ID_W-1:0]          src_id,
    output logic [HEX_W-1:0]         hex_out,
    output logic                     blank
);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [ID_W-1:0]  LAST_IDX   = ID_W'(SRC_NUM - 1);

    arb_state_e         state;
    logic [ID_W-1:0]    last;
    logic [CNT_W-1:0]   count;
    logic [ID_W-1:0]    start_idx;
    logic               dwell_done;
    logic               cur_req;
    logic               in_hold;
    logic               pick_found;
    logic [SRC_NUM-1:0] pick_onehot;
    logic [ID_W-1:0]    pick_idx;
    logic               do_grant;
    logic               do_release;

    // While holding, last equals the current holder, so one picker serves both states.
    assign start_idx  = (last == LAST_IDX) ? '0 : last + 1'b1;
    assign dwell_done = (count == DWELL_LAST);
    assign cur_req    = req[last];
    assign in_hold    = (state == HOLD);

    nf_rr_pick #(
        .N  (SRC_NUM),
        .IW (ID_W)
    ) u_pick (
        .req     (req),
        .start   (start_idx),
        .excl_en (in_hold),
        .found   (pick_found),
        .onehot  (pick_onehot),
        .idx     (pick_idx)
    );

    always_comb begin
        do_grant   = 1'b0;
        do_release = 1'b0;
        case (state)
            IDLE: do_grant = pick_found;
            HOLD: begin
                if (!cur_req) begin
                    do_grant   = pick_found;
                    do_release = !pick_found;
                end else begin
                    do_grant = dwell_done && !freeze && pick_found;
                end
            end
            default: ;
        endcase
    end

    // A drop always wins over dwell expiry; freeze only blocks the dwell-based switch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            src_id  <= '0;
            last    <= LAST_IDX;
            count   <= '0;
            hex_out <= '0;
            blank   <= 1'b1;
        end else if (do_grant) begin
            state   <= HOLD;
            grant   <= pick_onehot;
            src_id  <= pick_idx;
            last    <= pick_idx;
            count   <= '0;
            blank   <= 1'b0;
            hex_out <= hex_in[HEX_W*pick_idx +: HEX_W];
        end else if (do_release) begin
            state <= IDLE;
            grant <= '0;
            count <= '0;
            blank <= 1'b1;
        end else if (in_hold) begin
            if (!dwell_done) begin
                count <= count + 1'b1;
            end
            hex_out <= hex_in[HEX_W*last +: HEX_W];
        end
    end

endmodule

// File: tb/tb_nf_hex_arb.sv
// Self-checking bench for nf_hex_arb: directed scenarios plus randomized traffic against a reference model.
module tb_nf_hex_arb;
    localparam int N  = 4;
    localparam int DW = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*32-1:0] hex_in;
    logic           freeze;
    logic [N-1:0]   grant;
    logic [1:0]     src_id;
    logic [31:0]    hex_out;
    logic           blank;

    int checks   = 0;
    int failures = 0;

    // Reference model state: who holds the display, for how long, and what was last shown.
    int          m_holder = -1;
    int          m_last   = N - 1;
    int          m_held   = 0;
    int          m_src    = 0;
    logic [31:0] m_hex    = '0;
    bit          m_valid  = 0;

    nf_hex_arb #(
        .SRC_NUM (N),
        .DWELL   (DW),
        .CNT_W   (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .hex_in  (hex_in),
        .freeze  (freeze),
        .grant   (grant),
        .src_id  (src_id),
        .hex_out (hex_out),
        .blank   (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] hexv(input int i);
        return 32'hA0A0_0000 + 32'(i);
    endfunction

    function automatic int rr_search(input int from, input logic [N-1:0] r, input int excl);
        for (int k = 0; k < N; k++) begin
            int p;
            p = (from + k) % N;
            if (p != excl && r[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_take(input int n);
        m_holder = n;
        m_last   = n;
        m_src    = n;
        m_held   = 0;
        m_hex    = hex_in[32*n +: 32];
    endtask

    always @(posedge clk) begin
        int other;
        if (reset) begin
            m_holder = -1;
            m_last   = N - 1;
            m_held   = 0;
            m_src    = 0;
            m_hex    = '0;
            m_valid  = 1;
        end else if (m_holder < 0) begin
            other = rr_search(m_last + 1, req, -1);
            if (other >= 0) model_take(other);
        end else begin
            other = rr_search(m_holder + 1, req, m_holder);
            if (!req[m_holder]) begin
                if (other >= 0) model_take(other);
                else m_holder = -1;
            end else if (m_held >= DW - 1 && !freeze && other >= 0) begin
                model_take(other);
            end else begin
                m_held = m_held + 1;
                m_hex  = hex_in[32*m_holder +: 32];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [N-1:0] eg, input int es,
                               input logic [31:0] eh, input logic eb);
        checks++;
        if (grant !== eg || int'(src_id) != es || hex_out !== eh || blank !== eb) begin
            failures++;
            $display("[TB] FAIL %s: got grant=%b src_id=%0d hex_out=%h blank=%b, expected grant=%b src_id=%0d hex_out=%h blank=%b",
                     name, grant, src_id, hex_out, blank, eg, es, eh, eb);
        end
    endtask

    // Every cycle once the model is known: outputs against the model, and grant never multi-hot.
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model", (m_holder < 0) ? '0 : (N'(1) << m_holder), m_src, m_hex, m_holder < 0);
            checks++;
            if (!$onehot0(grant)) begin
                failures++;
                $display("[TB] FAIL onehot0: got grant=%b, expected at most one bit set", grant);
            end
        end
    end

    task automatic applyStimulus(input logic [N-1:0] r, input logic f, input logic rst);
        req    = r;
        freeze = f;
        reset  = rst;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        applyStimulus('0, 1'b0, 1'b1);
        tick();
    endtask

    initial begin
        applyStimulus('0, 1'b0, 1'b1);
        hex_in = '0;
        repeat (3) tick();
        checkOutput("reset_state", 4'b0000, 0, 32'h0, 1'b1);

        // Idle with no requests
        applyStimulus(4'b0000, 1'b0, 1'b0);
        repeat (10) begin
            tick();
            checkOutput("idle_no_req", 4'b0000, 0, 32'h0, 1'b1);
        end

        // Single request, then live value tracking, then release
        hex_in[32*2 +: 32] = 32'h0000_BEEF;
        applyStimulus(4'b0100, 1'b0, 1'b0);
        tick();
        checkOutput("first_grant", 4'b0100, 2, 32'h0000_BEEF, 1'b0);
        hex_in[32*2 +: 32] = 32'h0000_CAFE;
        tick();
        checkOutput("hex_follow", 4'b0100, 2, 32'h0000_CAFE, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        tick();
        checkOutput("release_idle", 4'b0000, 2, 32'h0000_CAFE, 1'b1);

        // Round robin over 1011 with four-cycle dwell
        for (int i = 0; i < N; i++) hex_in[32*i +: 32] = hexv(i);
        reset_pulse();
        applyStimulus(4'b1011, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            int s;
            s = (k < 4) ? 0 : (k < 8) ? 1 : (k < 12) ? 3 : 0;
            tick();
            checkOutput("rr_dwell", N'(1) << s, s, hexv(s), 1'b0);
        end

        // Holder drops mid-dwell with another requester waiting
        reset_pulse();
        applyStimulus(4'b0011, 1'b0, 1'b0);
        tick();
        checkOutput("drop_setup", 4'b0001, 0, hexv(0), 1'b0);
        tick();
        applyStimulus(4'b0010, 1'b0, 1'b0);
        tick();
        checkOutput("drop_to_other", 4'b0010, 1, hexv(1), 1'b0);
        tick();
        checkOutput("drop_other_holds", 4'b0010, 1, hexv(1), 1'b0);

        // Holder drops with nobody else requesting
        reset_pulse();
        applyStimulus(4'b0011, 1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        tick();
        checkOutput("drop_to_idle", 4'b0000, 0, hexv(0), 1'b1);

        // Freeze holds past dwell, release of freeze switches immediately
        reset_pulse();
        applyStimulus(4'b0010, 1'b0, 1'b0);
        tick();
        checkOutput("freeze_setup", 4'b0010, 1, hexv(1), 1'b0);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        repeat (20) begin
            tick();
            checkOutput("freeze_hold", 4'b0010, 1, hexv(1), 1'b0);
        end
        applyStimulus(4'b1111, 1'b0, 1'b0);
        tick();
        checkOutput("unfreeze_switch", 4'b0100, 2, hexv(2), 1'b0);

        // Reset during hold
        applyStimulus(4'b1111, 1'b0, 1'b1);
        tick();
        checkOutput("reset_in_hold", 4'b0000, 0, 32'h0, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        tick();
        checkOutput("after_reset", 4'b0001, 0, hexv(0), 1'b0);

        // Randomized traffic checked by the model each cycle
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r;
            logic         f;
            r = req;
            f = freeze;
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 9) == 0) f = ~f;
            if ($urandom_range(0, 2) == 0) hex_in[32*$urandom_range(0, N-1) +: 32] = $urandom;
            applyStimulus(r, f, $urandom_range(0, 299) == 0);
            tick();
        end

        applyStimulus('0, 1'b0, 1'b0);
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
